data_sram_resp: RTL and testbench

- Responder end of the data SRAM interface driven by the EX/MEM pipeline stages.
- Accepts word reads and byte-enabled writes, and returns read data one cycle after the access is performed. The MEM stage samples it as data_sram_rdata.
- Optionally inserts programmable wait states, requesting a pipeline stall through stallreq while the access is held off.
- Used as the on-chip data memory in simulation and FPGA builds.

---
 rtl/data_sram_resp_pkg.sv | 20 ++
 rtl/data_sram_ram.sv | 40 ++++
 rtl/data_sram_resp.sv | 78 +++++++
 tb/tb_data_sram_resp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared constants and helpers for the data SRAM responder.
package data_sram_resp_pkg;

    // Default word-address width and wait-state count for instantiation.
    localparam int DataSramAddrW = 10;
    localparam int DataSramWait  = 0;

    // Byte-enable pattern that marks a read request.
    localparam logic [3:0] WenRead = 4'b0000;

    // Wait counter width and the largest wait count it can represent.
    localparam int CntW    = 4;
    localparam int MaxWait = 15;

    // Request decode: any enabled byte lane turns the access into a write.
    function automatic logic is_write(input logic [3:0] wen);
        return wen != WenRead;
    endfunction

endpackage : data_sram_resp_pkg

// File: rtl/data_sram_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a
// registered, enable-gated read port. Contents are not reset.
module data_sram_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    localparam int Depth = 1 << ADDR_W;

    logic [31:0] mem_q [Depth];
    logic [31:0] rdata_q;

    // Byte-lane writes; lanes with a clear enable keep their old contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Read register captures only on a performed read and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'b0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : data_sram_ram

// File: rtl/data_sram_resp.sv
// Data SRAM responder: optional wait states with a stall request, then a
// single-cycle word read or byte-enabled write into the on-chip RAM.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_W      = DataSramAddrW,
    parameter int WAIT_CYCLES = DataSramWait
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq
);

    // The wait counter is 4 bits wide, so larger wait counts cannot be honoured.
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > MaxWait) begin : g_bad_wait
        $error("data_sram_resp: WAIT_CYCLES must be within 0..15");
    end

    localparam logic [CntW-1:0] WaitLim = CntW'(WAIT_CYCLES);

    logic [CntW-1:0]   cnt_q;
    logic [CntW-1:0]   cnt_d;
    logic              at_limit;
    logic              perform;
    logic [3:0]        ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] word_idx;
    logic              unused_addr_bits;

    // High byte-address bits alias onto the same word; byte offset is ignored.
    assign word_idx         = data_sram_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // The access happens on the edge where the counter has reached the limit.
    // Reset masks both the stall and the access so a pending request is dropped.
    assign at_limit = (cnt_q == WaitLim);
    assign stallreq = data_sram_en && !rst && !at_limit;
    assign perform  = data_sram_en && !rst && at_limit;
    assign ram_we   = perform ? data_sram_wen : 4'b0000;
    assign ram_re   = perform && !is_write(data_sram_wen);

    // Next wait count: count up while held off, clear on perform or cancel.
    always_comb begin
        cnt_d = cnt_q;
        if (!data_sram_en || at_limit) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    data_sram_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .idx_i   (word_idx),
        .wdata_i (data_sram_wdata),
        .rdata_o (data_sram_rdata)
    );

endmodule : data_sram_resp

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp with three wait-state configurations.
module tb_data_sram_resp;

    logic clk = 1'b0;
    logic rst;
    logic rst2;

    // WAIT_CYCLES = 0 instance
    logic        en0;
    logic [3:0]  wen0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        stall0;

    // WAIT_CYCLES = 3 instance
    logic        en3;
    logic [3:0]  wen3;
    logic [31:0] addr3, wdata3, rdata3;
    logic        stall3;

    // WAIT_CYCLES = 2 instance, with its own reset
    logic        en2;
    logic [3:0]  wen2;
    logic [31:0] addr2, wdata2, rdata2;
    logic        stall2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en0),
        .data_sram_wen   (wen0),
        .data_sram_addr  (addr0),
        .data_sram_wdata (wdata0),
        .data_sram_rdata (rdata0),
        .stallreq        (stall0)
    );

    data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) dut3 (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en3),
        .data_sram_wen   (wen3),
        .data_sram_addr  (addr3),
        .data_sram_wdata (wdata3),
        .data_sram_rdata (rdata3),
        .stallreq        (stall3)
    );

    data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
        .clk             (clk),
        .rst             (rst2),
        .data_sram_en    (en2),
        .data_sram_wen   (wen2),
        .data_sram_addr  (addr2),
        .data_sram_wdata (wdata2),
        .data_sram_rdata (rdata2),
        .stallreq        (stall2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count consecutive stall cycles on the WAIT_CYCLES=3 instance (bounded).
    task automatic count_stall3(output int n);
        n = 0;
        while (stall3 === 1'b1 && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic count_stall2(output int n);
        n = 0;
        while (stall2 === 1'b1 && n < 20) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; rst2 = 1'b1;
        en0 = 1'b0; wen0 = 4'h0; addr0 = '0; wdata0 = '0;
        en3 = 1'b0; wen3 = 4'h0; addr3 = '0; wdata3 = '0;
        en2 = 1'b0; wen2 = 4'h0; addr2 = '0; wdata2 = '0;
        tick();
        tick();

        // Reset state
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_stall0", {31'b0, stall0}, 32'h0);
        chk("rst_rdata3", rdata3, 32'h0);
        chk("rst_rdata2", rdata2, 32'h0);
        rst = 1'b0; rst2 = 1'b0;
        tick();

        // ---------------- WAIT_CYCLES = 0 ----------------
        en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        #1 chk("w0_wr_stall", {31'b0, stall0}, 32'h0);
        tick();
        chk("w0_wr_rdata_hold", rdata0, 32'h0);
        wen0 = 4'h0; addr0 = 32'h10; wdata0 = 32'h0;
        #1 chk("w0_rd_stall", {31'b0, stall0}, 32'h0);
        tick();
        chk("w0_rd_0x10", rdata0, 32'hDEADBEEF);

        // Byte lanes
        wen0 = 4'hF; addr0 = 32'h20; wdata0 = 32'h11223344;
        tick();
        chk("w0_wr_rdata_hold2", rdata0, 32'hDEADBEEF);
        wen0 = 4'b0101; wdata0 = 32'hAABBCCDD;
        tick();
        wen0 = 4'h0;
        tick();
        chk("w0_byte_lanes", rdata0, 32'h11BB33DD);

        // Aliasing: 0x1008 maps to the same word as 0x8
        wen0 = 4'hF; addr0 = 32'h1008; wdata0 = 32'hCAFEF00D;
        tick();
        wen0 = 4'h0; addr0 = 32'h8;
        tick();
        chk("w0_alias", rdata0, 32'hCAFEF00D);

        // Back-to-back write then read of the same word, different byte offset
        wen0 = 4'hF; addr0 = 32'h8; wdata0 = 32'h0BADC0DE;
        tick();
        wen0 = 4'h0; addr0 = 32'hB;
        tick();
        chk("w0_raw", rdata0, 32'h0BADC0DE);
        chk("w0_stall_end", {31'b0, stall0}, 32'h0);

        // Idle: rdata held
        en0 = 1'b0;
        tick();
        chk("w0_idle_hold", rdata0, 32'h0BADC0DE);

        // ---------------- WAIT_CYCLES = 3 ----------------
        // Preload 0x10 with DEADBEEF
        en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h10; wdata3 = 32'hDEADBEEF;
        #1;
        count_stall3(n);
        chk("w3_wr_stall_cnt", n, 32'd3);
        tick();
        en3 = 1'b0; wen3 = 4'h0;
        tick();
        chk("w3_wr_rdata_hold", rdata3, 32'h0);

        // Read held with en=1
        en3 = 1'b1; wen3 = 4'h0; addr3 = 32'h10;
        #1 chk("w3_rd_stall_first", {31'b0, stall3}, 32'h1);
        count_stall3(n);
        chk("w3_rd_stall_cnt", n, 32'd3);
        chk("w3_rd_not_yet", rdata3, 32'h0);
        tick();
        en3 = 1'b0;
        #1 chk("w3_rd_data", rdata3, 32'hDEADBEEF);
        chk("w3_idle_stall", {31'b0, stall3}, 32'h0);
        tick();

        // Cancel a write after two stall cycles
        en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h10; wdata3 = 32'h12345678;
        tick();
        tick();
        chk("w3_cancel_pre", {31'b0, stall3}, 32'h1);
        en3 = 1'b0;
        #1 chk("w3_cancel_drop", {31'b0, stall3}, 32'h0);
        tick();
        // Counter must be back at zero: the next request stalls a full 3 cycles
        en3 = 1'b1; wen3 = 4'h0; addr3 = 32'h10; wdata3 = 32'h0;
        #1;
        count_stall3(n);
        chk("w3_after_cancel_cnt", n, 32'd3);
        tick();
        en3 = 1'b0;
        #1 chk("w3_no_write", rdata3, 32'hDEADBEEF);

        // ---------------- WAIT_CYCLES = 2, reset mid-wait ----------------
        en2 = 1'b1; wen2 = 4'hF; addr2 = 32'h40; wdata2 = 32'h55AA55AA;
        #1;
        count_stall2(n);
        chk("w2_wr_stall_cnt", n, 32'd2);
        tick();
        wen2 = 4'h0;
        #1;
        count_stall2(n);
        tick();
        chk("w2_rd_data", rdata2, 32'h55AA55AA);
        // Pending write with cnt=1
        wen2 = 4'hF; wdata2 = 32'hFFFFFFFF;
        tick();
        chk("w2_mid_stall", {31'b0, stall2}, 32'h1);
        #2 rst2 = 1'b1;
        #1;
        chk("w2_rst_stall", {31'b0, stall2}, 32'h0);
        chk("w2_rst_rdata", rdata2, 32'h0);
        en2 = 1'b0; wen2 = 4'h0;
        tick();
        rst2 = 1'b0;
        tick();
        en2 = 1'b1; wen2 = 4'h0; addr2 = 32'h40;
        #1;
        count_stall2(n);
        chk("w2_post_rst_cnt", n, 32'd2);
        tick();
        en2 = 1'b0;
        #1 chk("w2_word_unchanged", rdata2, 32'h55AA55AA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_data_sram_resp
